dac_cmd_sender: RTL
===================

# dac_cmd_sender

Host-side command initiator for the DAC controller's UART byte protocol. It accepts one high-level request (opcode plus up to 32-bit argument), serializes the opcode byte and little-endian payload bytes onto a `uart_top`-style transmit handshake, and collects read-back bytes where the opcode returns data. It sits between an on-board sequencer or test harness and a UART transmitter/receiver pair. It drives the DAC controller's state machine exactly as a PC host would.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32'd1000000: per-byte read-back timeout, in clk cycles.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, request accepted when req_valid&req_ready.
- req_op  in  5  command opcode, sent verbatim as byte {3'b000, req_op}.
- req_arg  in  32  command argument.
- rsp_valid  out  1  one-cycle pulse, command finished.
- rsp_data  out  16  read-back value, 0 for write commands.
- rsp_err  out  1  qualifies rsp_valid: illegal opcode, nothing sent.
- rsp_timeout  out  1  qualifies rsp_valid: read-back byte missing.
- tx_data  out  8  byte to transmitter.
- new_tx_data  out  1  one-cycle transmit strobe.
- tx_busy  in  1  transmitter busy.
- rx_data  in  8  received byte.
- new_rx_data  in  1  one-cycle receive strobe.

## Operation
- Payload bytes per opcode, each sent low byte first from req_arg:
  - 0 (break, returns NORM_MODE to IDLE): 0 payload.
  - 1 (load data): 2 payload bytes, arg[7:0] then {1'b0, arg[14:8]}.
  - 2 (load adr): 1 payload byte, {5'b0, arg[2:0]}.
  - 5 (norm mode): 0 payload.
  - 8 (status): 1 payload byte, arg[7:0].
  - 9 (data count): 4 payload bytes.
  - 10 (RAM end): 4 payload bytes.
  - 11 (RAM word): 2 payload bytes, arg[15:0].
  - 13 (read RAM to data): 0 payload.
  - 17 (read data count): 0 payload; 2 bytes received.
  - 19 (div clk): 4 payload bytes.
  - All other opcodes: illegal.
- States:
  - IDLE: req_ready=1. On accept, latch op and arg, load the byte counter, and go to SEND. An illegal op instead goes to IDLE with rsp_valid=rsp_err=1 and no byte sent.
  - SEND: wait for !tx_busy. Then register tx_data and new_tx_data=1, and go to GUARD.
  - GUARD: one cycle with tx_busy ignored, covering the transmitter's registered busy. Next state:
    - SEND if bytes remain;
    - RX_WAIT for op 17;
    - otherwise IDLE with rsp_valid pulse.
  - RX_WAIT:
    - Capture the first new_rx_data into rsp_data[7:0] and the second into rsp_data[15:8], then go to IDLE with rsp_valid.
    - Timeout counter clears on each received byte. Reaching TIMEOUT_CYCLES goes to IDLE with rsp_valid=rsp_timeout=1; rsp_data holds the bytes received so far, with missing bytes set to 0.
- new_rx_data outside RX_WAIT is ignored.
- A request is never accepted while not IDLE; req_op and req_arg are don't-care after acceptance.
- rsp_err and rsp_timeout are 0 whenever rsp_valid is 0.

## Timing
- Reset values:
  - state IDLE, req_ready 1;
  - rsp_valid, rsp_err, rsp_timeout, new_tx_data 0;
  - tx_data 8'h00, rsp_data 16'h0000;
  - counters 0.
- Reset mid-command aborts immediately: no rsp_valid, and no further new_tx_data.
- With tx_busy tied 0 and acceptance on edge E0:
  - first new_tx_data is high in cycle 2;
  - subsequent strobes follow every 2 cycles;
  - rsp_valid is high in cycle 2n+1 for n bytes total.
- req_ready is 0 from the cycle after acceptance until the cycle rsp_valid is high; req_ready=1 in that same cycle, so back-to-back requests are allowed.
- tx_data is stable during and after its strobe until the next strobe.
- Illegal op: rsp_valid in cycle 1.
- Timeout counter is 32-bit and saturates at TIMEOUT_CYCLES. It starts in the first RX_WAIT cycle.

## Configuration
- DAC_CMD_SENDER_READBACK_EN defined: op 17 and RX_WAIT are supported as above.
- Not defined: op 17 is illegal (rsp_err). RX_WAIT and the timeout counter are removed. rx_data and new_rx_data are unused. rsp_data and rsp_timeout are tied 0.

## Test plan
- tx_busy=0, op 9, arg 32'h12345678 -> strobes in cycles 2/4/6/8/10 with bytes 09,78,56,34,12; rsp_valid cycle 11, rsp_data 0.
- op 1, arg 16'hFFFF with tx_busy held 1 for 20 cycles after each strobe -> bytes 01,FF,7F, each strobe only after busy falls; no strobe while busy.
- op 17 (READBACK_EN), bench returns 34 then 12 -> byte 11 sent, rsp_data 16'h1234, rsp_timeout 0.
- op 17, bench returns only 34, TIMEOUT_CYCLES=100 -> rsp_valid with rsp_timeout=1, rsp_data 16'h0034, about 100 cycles after the last byte.
- op 3 -> no strobe; rsp_valid and rsp_err in cycle 1; next request accepted the same cycle.
- rstn low mid op 19 after 2 bytes -> outputs at reset values; subsequent op 5 sends exactly byte 05.

Source files
------------

// File: rtl/dac_cmd_sender.sv
// dac_cmd_sender: host-side command initiator for the DAC controller UART byte protocol.
// Latency: first tx strobe 2 cycles after accept, one byte per 2 cycles with tx idle, rsp 1 cycle after last byte.
// Backpressure: req_ready low while a command is in flight; each byte waits for !tx_busy.
//
// Ports: clk/rstn (async active-low); req_valid/req_ready/req_op/req_arg request handshake;
//        rsp_valid/rsp_data/rsp_err/rsp_timeout completion pulse; tx_data/new_tx_data/tx_busy
//        transmitter side; rx_data/new_rx_data receiver side (read-back only).
// Build option: DAC_CMD_SENDER_READBACK_EN enables op 17 (read data count) with its 2-byte
//               read-back and per-byte timeout; without it op 17 is rejected as illegal.
module dac_cmd_sender #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [31:0] req_arg,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic [7:0]  tx_data,
   output logic        new_tx_data,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        new_rx_data
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GUARD
`ifdef DAC_CMD_SENDER_READBACK_EN
      , ST_RX_WAIT
`endif
   } state_t;

   state_t      state_q, state_nxt;
   logic [39:0] shift_q;      // remaining bytes, next one to send in [7:0]
   logic [2:0]  byte_cnt;     // bytes still to send, opcode included
   logic        accept, send, done, err;

   function automatic logic op_legal(input logic [4:0] op);
      case (op)
         5'd0, 5'd1, 5'd2, 5'd5, 5'd8, 5'd9, 5'd10, 5'd11, 5'd13, 5'd19: op_legal = 1'b1;
`ifdef DAC_CMD_SENDER_READBACK_EN
         5'd17:   op_legal = 1'b1;
`endif
         default: op_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] payload_len(input logic [4:0] op);
      case (op)
         5'd1, 5'd11:         payload_len = 3'd2;
         5'd2, 5'd8:          payload_len = 3'd1;
         5'd9, 5'd10, 5'd19:  payload_len = 3'd4;
         default:             payload_len = 3'd0;
      endcase
   endfunction

   // Ops whose payload fields are narrower than a byte get their spare bits forced to 0.
   function automatic logic [31:0] arg_mask(input logic [4:0] op, input logic [31:0] arg);
      case (op)
         5'd1:    arg_mask = {17'h0, arg[14:0]};
         5'd2:    arg_mask = {29'h0, arg[2:0]};
         default: arg_mask = arg;
      endcase
   endfunction

`ifdef DAC_CMD_SENDER_READBACK_EN
   logic [4:0]  op_q;
   logic        rx_idx;        // 0: expecting low byte, 1: expecting high byte
   logic [31:0] tmo_q, tmo_inc;
   logic        tmo_hit;
   logic [15:0] rsp_data_q;
   logic        rsp_timeout_q;

   assign tmo_inc = (tmo_q >= TIMEOUT_CYCLES) ? tmo_q : tmo_q + 32'd1;
`else
   logic unused_rx;
   assign unused_rx = ^{rx_data, new_rx_data, TIMEOUT_CYCLES};
`endif

   assign req_ready = (state_q == ST_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      accept    = 1'b0;
      send      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
`ifdef DAC_CMD_SENDER_READBACK_EN
      tmo_hit   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (op_legal(req_op)) state_nxt = ST_SEND;
               else                  err       = 1'b1;
            end
         end
         ST_SEND: begin
            if (!tx_busy) begin
               send      = 1'b1;
               state_nxt = ST_GUARD;
            end
         end
         // The transmitter raises busy one cycle after our strobe, so tx_busy is not trusted here.
         ST_GUARD: begin
            if (byte_cnt != 3'd0) state_nxt = ST_SEND;
`ifdef DAC_CMD_SENDER_READBACK_EN
            else if (op_q == 5'd17) state_nxt = ST_RX_WAIT;
`endif
            else begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
`ifdef DAC_CMD_SENDER_READBACK_EN
         ST_RX_WAIT: begin
            if (new_rx_data) begin
               if (rx_idx) begin
                  done      = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end else if (tmo_inc >= TIMEOUT_CYCLES) begin
               tmo_hit   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shift_q     <= 40'h0;
         byte_cnt    <= 3'd0;
         tx_data     <= 8'h00;
         new_tx_data <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
      end else begin
         new_tx_data <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         if (accept) begin
            shift_q  <= {arg_mask(req_op, req_arg), 3'b000, req_op};
            byte_cnt <= payload_len(req_op) + 3'd1;
            if (err) begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
            end
         end
         if (send) begin
            tx_data     <= shift_q[7:0];
            new_tx_data <= 1'b1;
            shift_q     <= {8'h00, shift_q[39:8]};
            byte_cnt    <= byte_cnt - 3'd1;
         end
         if (done) rsp_valid <= 1'b1;
`ifdef DAC_CMD_SENDER_READBACK_EN
         if (tmo_hit) rsp_valid <= 1'b1;
`endif
      end
   end

`ifdef DAC_CMD_SENDER_READBACK_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_q          <= 5'd0;
         rx_idx        <= 1'b0;
         tmo_q         <= 32'd0;
         rsp_data_q    <= 16'h0000;
         rsp_timeout_q <= 1'b0;
      end else begin
         rsp_timeout_q <= tmo_hit;
         if (accept) begin
            op_q       <= req_op;
            rx_idx     <= 1'b0;
            tmo_q      <= 32'd0;
            rsp_data_q <= 16'h0000;
         end
         if (state_q == ST_RX_WAIT) begin
            if (new_rx_data) begin
               if (rx_idx) rsp_data_q[15:8] <= rx_data;
               else        rsp_data_q[7:0]  <= rx_data;
               rx_idx <= 1'b1;
               tmo_q  <= 32'd0;
            end else begin
               tmo_q <= tmo_inc;
            end
         end
      end
   end

   assign rsp_data    = rsp_data_q;
   assign rsp_timeout = rsp_timeout_q;
`else
   assign rsp_data    = 16'h0000;
   assign rsp_timeout = 1'b0;
`endif

endmodule
